// File: rtl/pingpong_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_counter_param
//  Purpose  : Parametrised bounded counter with three count modes:
//             ping-pong, wrap-up and wrap-down. It adds runtime bounds,
//             a programmable step, synchronous load, a direction flip
//             and a one-cycle pulse on every reversal or wrap.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      rising-edge clock
//    rst_n        in   1      asynchronous active-low reset
//    enable_i     in   1      count enable (low = hold)
//    mode_i       in   2      0 ping-pong, 1 wrap-up, 2 wrap-down, 3 freeze
//    lo_i         in   WIDTH  lower bound (inclusive)
//    hi_i         in   WIDTH  upper bound (inclusive)
//    step_i       in   WIDTH  increment per enabled cycle
//    flip_i       in   1      invert direction this cycle (ping-pong only)
//    load_i       in   1      synchronous load request
//    load_val_i   in   WIDTH  value to load (clamped to [lo,hi])
//    out_o        out  WIDTH  registered count
//    direction_o  out  1      registered, 0 = last move up, 1 = last move down
//    bound_evt_o  out  1      registered one-cycle pulse on reversal or wrap
//    cfg_err_o    out  1      combinational, high while lo > hi
// ============================================================================
module pingpong_counter_param #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             flip_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] out_o,
  output logic             direction_o,
  output logic             bound_evt_o,
  output logic             cfg_err_o
);

  localparam logic [1:0] MODE_PINGPONG = 2'd0;
  localparam logic [1:0] MODE_WRAPUP   = 2'd1;
  localparam logic [1:0] MODE_WRAPDN   = 2'd2;
  localparam logic [1:0] MODE_FREEZE   = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             evt_q, evt_d;

  // All arithmetic is carried one bit wider so that sums above 2^WIDTH-1
  // and differences below zero are visible and never wrap silently.
  logic [WIDTH:0] out_x, lo_x, hi_x, step_x, lv_x;
  logic [WIDTH:0] up_sum;     // out + step
  logic [WIDTH:0] dn_diff;    // out - step (valid only when out >= step)
  logic [WIDTH:0] lo_plus;    // lo + step
  logic [WIDTH:0] hi_minus;   // hi - step (valid only when hi >= step)
  logic           dn_ok;      // out - step does not underflow
  logic           hi_m_ok;    // hi - step does not underflow
  logic           eff_dir;    // ping-pong direction after flip

  assign out_x  = {1'b0, out_q};
  assign lo_x   = {1'b0, lo_i};
  assign hi_x   = {1'b0, hi_i};
  assign step_x = {1'b0, step_i};
  assign lv_x   = {1'b0, load_val_i};

  assign up_sum   = out_x + step_x;
  assign dn_diff  = out_x - step_x;
  assign lo_plus  = lo_x + step_x;
  assign hi_minus = hi_x - step_x;
  assign dn_ok    = (out_x >= step_x);
  assign hi_m_ok  = (hi_x >= step_x);
  assign eff_dir  = dir_q ^ flip_i;

  assign cfg_err_o = (lo_i > hi_i);

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    evt_d = 1'b0;

    if (cfg_err_o) begin
      // Inconsistent bounds: freeze everything, including loads.
    end else if (load_i) begin
      if (lv_x < lo_x) begin
        out_d = lo_i;
      end else if (lv_x > hi_x) begin
        out_d = hi_i;
      end else begin
        out_d = load_val_i;
      end
    end else if (!enable_i || (mode_i == MODE_FREEZE)) begin
      // Hold.
    end else if (out_x < lo_x) begin
      // Bounds moved past the current value: pull back in, no step.
      out_d = lo_i;
      dir_d = DIR_UP;
    end else if (out_x > hi_x) begin
      out_d = hi_i;
      dir_d = DIR_DOWN;
    end else if (step_i == '0) begin
      // Zero step is a hold in every mode.
    end else begin
      case (mode_i)
        MODE_PINGPONG: begin
          if (eff_dir == DIR_UP) begin
            if (out_q == hi_i) begin
              // Reverse at the top; land no lower than lo.
              out_d = (hi_m_ok && (hi_minus >= lo_x)) ? hi_minus[WIDTH-1:0] : lo_i;
              dir_d = DIR_DOWN;
              evt_d = 1'b1;
            end else begin
              // Saturate on the approach so hi itself is visited.
              out_d = (up_sum > hi_x) ? hi_i : up_sum[WIDTH-1:0];
              dir_d = DIR_UP;
            end
          end else begin
            if (out_q == lo_i) begin
              out_d = (lo_plus > hi_x) ? hi_i : lo_plus[WIDTH-1:0];
              dir_d = DIR_UP;
              evt_d = 1'b1;
            end else begin
              out_d = (dn_ok && (dn_diff >= lo_x)) ? dn_diff[WIDTH-1:0] : lo_i;
              dir_d = DIR_DOWN;
            end
          end
        end
        MODE_WRAPUP: begin
          dir_d = DIR_UP;
          if (up_sum > hi_x) begin
            out_d = lo_i;
            evt_d = 1'b1;
          end else begin
            out_d = up_sum[WIDTH-1:0];
          end
        end
        MODE_WRAPDN: begin
          dir_d = DIR_DOWN;
          // out < lo + step also covers out < step, so dn_diff is safe below.
          if (out_x < lo_plus) begin
            out_d = hi_i;
            evt_d = 1'b1;
          end else begin
            out_d = dn_diff[WIDTH-1:0];
          end
        end
        default: begin
          // Freeze is handled above.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RST_VAL;
      dir_q <= DIR_UP;
      evt_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      evt_q <= evt_d;
    end
  end

  assign out_o       = out_q;
  assign direction_o = dir_q;
  assign bound_evt_o = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pingpong_counter_param
//  Purpose  : Scoreboard bench for pingpong_counter_param. The driver issues
//             one input set per cycle and pushes the reference model's
//             expected outputs; a monitor pops and compares after each edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_counter_param;

  localparam int         WIDTH   = 4;
  localparam logic [3:0] RST_VAL = 4'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [3:0] lo_i = 4'd0;
  logic [3:0] hi_i = 4'd15;
  logic [3:0] step_i = 4'd1;
  logic       flip_i = 1'b0;
  logic       load_i = 1'b0;
  logic [3:0] load_val_i = 4'd0;
  logic [3:0] out_o;
  logic       direction_o;
  logic       bound_evt_o;
  logic       cfg_err_o;

  pingpong_counter_param #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .mode_i      (mode_i),
    .lo_i        (lo_i),
    .hi_i        (hi_i),
    .step_i      (step_i),
    .flip_i      (flip_i),
    .load_i      (load_i),
    .load_val_i  (load_val_i),
    .out_o       (out_o),
    .direction_o (direction_o),
    .bound_evt_o (bound_evt_o),
    .cfg_err_o   (cfg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out;
    int dir;
    int evt;
    int cfg;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state.
  int m_out = 0;
  int m_dir = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, want, $time);
    end
  endtask

  // Next-state rules evaluated with signed integers: negative or oversized
  // intermediate results simply compare against the bounds.
  task automatic model_next(input bit en, input int md, input int lo, input int hi,
                            input int st, input bit fl, input bit ld, input int lv,
                            output exp_t e);
    int o;
    int d;
    int ev;
    o  = m_out;
    d  = m_dir;
    ev = 0;
    if (lo > hi) begin
    end else if (ld) begin
      o = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
    end else if (!en || md == 3) begin
    end else if (o < lo) begin
      o = lo; d = 0;
    end else if (o > hi) begin
      o = hi; d = 1;
    end else if (st == 0) begin
    end else if (md == 0) begin
      if ((m_dir ^ int'(fl)) == 0) begin
        if (o == hi) begin
          o = (hi - st < lo) ? lo : hi - st; d = 1; ev = 1;
        end else begin
          o = (o + st > hi) ? hi : o + st; d = 0;
        end
      end else begin
        if (o == lo) begin
          o = (lo + st > hi) ? hi : lo + st; d = 0; ev = 1;
        end else begin
          o = (o - st < lo) ? lo : o - st; d = 1;
        end
      end
    end else if (md == 1) begin
      d = 0;
      if (o + st > hi) begin o = lo; ev = 1; end
      else o = o + st;
    end else begin
      d = 1;
      if (o - st < lo) begin o = hi; ev = 1; end
      else o = o - st;
    end
    m_out = o;
    m_dir = d;
    e.out = o;
    e.dir = d;
    e.evt = ev;
    e.cfg = (lo > hi) ? 1 : 0;
  endtask

  // Drive one cycle's inputs (caller is just after a falling edge).
  task automatic apply(input bit en, input int md, input int lo, input int hi,
                       input int st, input bit fl, input bit ld, input int lv);
    exp_t e;
    enable_i   = en;
    mode_i     = 2'(md);
    lo_i       = 4'(lo);
    hi_i       = 4'(hi);
    step_i     = 4'(st);
    flip_i     = fl;
    load_i     = ld;
    load_val_i = 4'(lv);
    model_next(en, md, lo, hi, st, fl, ld, lv, e);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit en, input int md, input int lo, input int hi,
                     input int st, input bit fl, input bit ld, input int lv);
    @(negedge clk);
    apply(en, md, lo, hi, st, fl, ld, lv);
  endtask

  // Asynchronous reset pulse between edges, then drive the next cycle.
  task automatic mid_reset(input bit en, input int md, input int lo, input int hi,
                           input int st);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_o), int'(RST_VAL));
    chk("async_rst_dir", 32'(direction_o), 0);
    chk("async_rst_evt", 32'(bound_evt_o), 0);
    m_out = int'(RST_VAL);
    m_dir = 0;
    #1 rst_n = 1'b1;
    apply(en, md, lo, hi, st, 1'b0, 1'b0, 0);
  endtask

  // Monitor: the DUT presents a result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out",       32'(out_o),       e.out);
        chk("direction", 32'(direction_o), e.dir);
        chk("bound_evt", 32'(bound_evt_o), e.evt);
        chk("cfg_err",   32'(cfg_err_o),   e.cfg);
      end
    end
  end

  initial begin
    int lo, hi, st, md, t;
    // Power-on reset.
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(out_o), int'(RST_VAL));
    chk("reset_dir", 32'(direction_o), 0);
    chk("reset_evt", 32'(bound_evt_o), 0);
    m_out = int'(RST_VAL);
    m_dir = 0;
    rst_n = 1'b1;

    // Legacy sequence 0..15..0.. then hold with enable low.
    repeat (40) cyc(1, 0, 0, 15, 1, 0, 0, 0);
    repeat (3)  cyc(0, 0, 0, 15, 1, 0, 0, 0);

    // Ping-pong with saturation: 3,7,10,6,3,7.
    cyc(1, 0, 3, 10, 4, 0, 1, 3);
    repeat (5) cyc(1, 0, 3, 10, 4, 0, 0, 0);

    // Wrap-up then wrap-down.
    cyc(1, 1, 2, 9, 3, 0, 1, 2);
    repeat (3) cyc(1, 1, 2, 9, 3, 0, 0, 0);
    repeat (4) cyc(1, 2, 2, 9, 3, 0, 0, 0);

    // Load clamps and overrides enable; load with flip keeps direction.
    cyc(0, 0, 0, 12, 1, 0, 1, 14);
    cyc(1, 0, 0, 12, 1, 1, 1, 5);

    // Mid-count asynchronous reset.
    repeat (4) cyc(1, 0, 0, 15, 2, 0, 0, 0);
    mid_reset(1, 0, 0, 15, 1);

    // Bad bounds freeze, then clamp up to lo.
    cyc(1, 0, 0, 12, 1, 0, 1, 5);
    repeat (3) cyc(1, 0, 8, 4, 1, 0, 1, 1);
    cyc(1, 0, 8, 12, 1, 0, 0, 0);

    // No overflow with large step near the top.
    cyc(1, 0, 0, 15, 1, 0, 1, 14);
    repeat (3) cyc(1, 0, 0, 15, 15, 0, 0, 0);

    // Degenerate range lo == hi.
    repeat (4) cyc(1, 0, 6, 6, 3, 0, 0, 0);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(0, 15);
      if (lo > hi && $urandom_range(0, 7) != 0) begin
        t = lo; lo = hi; hi = t;
      end
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      t  = $urandom_range(0, 9);
      md = (t < 5) ? 0 : (t < 7) ? 1 : (t < 9) ? 2 : 3;
      if ($urandom_range(0, 5) == 0) mid_reset(1, md, lo, hi, st);
      for (int c = 0; c < 20; c++) begin
        cyc($urandom_range(0, 9) != 0, md, lo, hi, st,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
